// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
//  Module   : master_port
//  Purpose  : Converts single-beat parallel read/write requests into the
//             serial request/grant + valid/ready bit-stream bus protocol.
//             Sends a 2-bit serial slave select, then shifts address and
//             write data LSB-first or collects read data LSB-first, holding
//             position whenever the grant is withdrawn (slave split).
//  Revision : 1.0 - initial release
// ============================================================================
module master_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  // local request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // arbiter side
  output logic                  m_request,
  output logic                  m_slave_sel,
  input  logic                  m_grant,
  output logic                  trans_done,
  // serial data side
  output logic                  m_master_valid,
  output logic                  m_master_ready,
  output logic                  m_tx_address,
  output logic                  m_tx_data,
  input  logic                  m_rx_data,
  output logic                  m_write_en,
  output logic                  m_read_en,
  input  logic                  m_slave_valid,
  input  logic                  m_slave_ready
);

  localparam int C_AW   = ADDR_WIDTH - 2;
  localparam int C_DW   = DATA_WIDTH;
  localparam int C_MAXW = (C_AW > C_DW) ? C_AW : C_DW;
  localparam int C_CW   = (C_MAXW > 1) ? $clog2(C_MAXW) : 1;

  localparam logic [C_CW-1:0] C_ALAST = C_CW'(C_AW - 1);
  localparam logic [C_CW-1:0] C_DLAST = C_CW'(C_DW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [1:0]      sid_q, sid_d;
  logic [C_AW-1:0] addr_q, addr_d;     // shifts right, bit 0 is on the wire
  logic [C_DW-1:0] wdata_q, wdata_d;   // shifts right, bit 0 is on the wire
  logic [C_DW-1:0] rdata_q, rdata_d;   // shifts in from the MSB end
  logic [C_DW-1:0] rsp_rdata_q, rsp_rdata_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      sid_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      sid_q       <= sid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and datapath update; grant loss simply blocks every transfer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    sid_d       = sid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          sid_d   = req_addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
          addr_d  = req_addr[C_AW-1:0];
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        // Two select cycles, counted on the low counter bit
        if (cnt_q[0]) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + C_CW'(1);
        end
      end
      S_WAIT: begin
        if (m_grant) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (m_grant && m_slave_ready) begin
          addr_d = addr_q >> 1;
          if (cnt_q == C_ALAST) begin
            cnt_d   = '0;
            state_d = write_q ? S_WDATA : S_RDATA;
          end else begin
            cnt_d = cnt_q + C_CW'(1);
          end
        end
      end
      S_WDATA: begin
        if (m_grant && m_slave_ready) begin
          wdata_d = wdata_q >> 1;
          if (cnt_q == C_DLAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + C_CW'(1);
          end
        end
      end
      S_RDATA: begin
        if (m_grant && m_slave_valid) begin
          rdata_d = {m_rx_data, rdata_q[C_DW-1:1]};
          if (cnt_q == C_DLAST) begin
            // Publish on the final capture so rsp_rdata is valid in DONE
            cnt_d       = '0;
            rsp_rdata_d = rdata_d;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + C_CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state, gated by grant and forced low in reset
  always_comb begin
    logic w_run;
    logic w_bus;
    w_run = ~sys_rst;
    w_bus = (state_q == S_WAIT) || (state_q == S_ADDR) ||
            (state_q == S_WDATA) || (state_q == S_RDATA);

    req_ready      = w_run && (state_q == S_IDLE);
    m_request      = w_run && (w_bus || (state_q == S_SEL));
    m_slave_sel    = w_run && (state_q == S_SEL) &&
                     (cnt_q[0] ? sid_q[0] : sid_q[1]);
    m_write_en     = w_run && w_bus && write_q;
    m_read_en      = w_run && w_bus && !write_q;
    m_master_valid = w_run && m_grant &&
                     ((state_q == S_ADDR) || (state_q == S_WDATA));
    m_master_ready = w_run && m_grant && (state_q == S_RDATA);
    m_tx_address   = w_run && m_grant && (state_q == S_ADDR) && addr_q[0];
    m_tx_data      = w_run && m_grant && (state_q == S_WDATA) && wdata_q[0];
    trans_done     = w_run && (state_q == S_DONE);
    rsp_valid      = w_run && (state_q == S_DONE);
    rsp_rdata      = w_run ? rsp_rdata_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_master_port
//  Purpose  : Self-checking bench for master_port: vector table of bus
//             transactions against an arbiter/slave model, scoreboard of
//             expected results, plus reset and back-to-back sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_master_port;

  localparam int A  = 12;
  localparam int DW = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        req_valid, req_ready, req_write;
  logic [13:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m_request, m_slave_sel, m_grant, trans_done;
  logic        m_master_valid, m_master_ready, m_tx_address, m_tx_data;
  logic        m_rx_data, m_write_en, m_read_en, m_slave_valid, m_slave_ready;

  always #5 sys_clk = ~sys_clk;

  master_port #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m_request(m_request), .m_slave_sel(m_slave_sel), .m_grant(m_grant),
    .trans_done(trans_done),
    .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
    .m_tx_address(m_tx_address), .m_tx_data(m_tx_data), .m_rx_data(m_rx_data),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_slave_valid(m_slave_valid), .m_slave_ready(m_slave_ready)
  );

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rword;     // word the slave returns on a read
    int          bp_at;     // ready low 5 cycles once this many bits moved (-1 off)
    int          split_at;  // grant low 10 cycles once this many bits moved (-1 off)
    bit          vmode;     // 1: slave_valid on alternate cycles
    int          lat;       // expected accept-to-DONE cycles (-1 unchecked)
  } vec_t;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, accept_cyc, done_cyc, nb, rb, sel_n, bp_cnt, sp_cnt, n_spur;
  int cur_bp, cur_split, cur_lat;
  bit cur_vmode, accepted, proto_ok;
  logic [7:0]  cur_rword, model_last;
  logic [11:0] obs_addr;
  logic [7:0]  obs_wd;
  logic [1:0]  obs_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: monitor at negedge, then drive arbiter/slave model after posedge
  task automatic tick();
    exp_t e;
    @(negedge sys_clk);
    if (sys_rst) begin
      check("reset_outputs_zero",
            {req_ready, rsp_valid, rsp_rdata, m_request, m_slave_sel, trans_done,
             m_master_valid, m_master_ready, m_tx_address, m_tx_data,
             m_write_en, m_read_en}, 32'd0);
      nb = 0; rb = 0; sel_n = 0;
    end else begin
      if (req_valid && req_ready) begin
        e.wr    = req_write;
        e.addr  = req_addr;
        e.wdata = req_wdata;
        e.rdata = req_write ? model_last : cur_rword;
        e.lat   = cur_lat;
        if (!req_write) model_last = cur_rword;
        sb.push_back(e);
        accept_cyc = cyc; accepted = 1'b1;
        nb = 0; rb = 0; sel_n = 0; bp_cnt = 0; sp_cnt = 0; proto_ok = 1'b1;
        obs_addr = '0; obs_wd = '0; obs_sel = '0;
      end
      if (m_request && !m_write_en && !m_read_en) begin
        obs_sel = {obs_sel[0], m_slave_sel};
        sel_n++;
      end
      if (!m_master_valid && (m_tx_address || m_tx_data)) proto_ok = 1'b0;
      if ((m_write_en || m_read_en) && (!m_request || req_ready)) proto_ok = 1'b0;
      if (m_write_en && m_read_en) proto_ok = 1'b0;
      if (!m_grant && (m_master_valid || m_master_ready)) proto_ok = 1'b0;
      if (m_master_ready && !m_read_en) proto_ok = 1'b0;
      if (m_master_valid && nb >= A && !m_write_en) proto_ok = 1'b0;
      if (m_master_valid && m_slave_ready) begin
        if (nb < A) obs_addr[nb] = m_tx_address;
        else if (nb < A + DW) obs_wd[nb-A] = m_tx_data;
        nb++;
      end
      if (m_master_ready && m_slave_valid) rb++;
      if (rsp_valid) begin
        done_cyc = cyc;
        if (sb.size() == 0) begin
          n_spur++;
        end else begin
          e = sb.pop_front();
          check("trans_done", {31'd0, trans_done}, 32'd1);
          check("done_bus_idle", {m_request, m_master_valid, m_master_ready,
                                  m_write_en, m_read_en}, 32'd0);
          check("slave_sel", {30'd0, obs_sel}, {30'd0, e.addr[13:12]});
          check("addr_stream", {20'd0, obs_addr}, {20'd0, e.addr[11:0]});
          if (e.wr) check("wdata_stream", {24'd0, obs_wd}, {24'd0, e.wdata});
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          check("bit_counts", {16'd0, nb[7:0], rb[7:0]},
                e.wr ? {16'd0, 8'(A + DW), 8'd0} : {16'd0, 8'(A), 8'(DW)});
          check("protocol", {29'd0, proto_ok, sel_n[1:0]}, {29'd0, 1'b1, 2'd2});
          if (e.lat >= 0) check("latency", cyc - accept_cyc, e.lat);
        end
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    m_grant = 1'b1;
    if (cur_split >= 0 && (nb + rb) == cur_split && sp_cnt < 10 &&
        (m_write_en || m_read_en)) begin
      m_grant = 1'b0;
      sp_cnt++;
    end
    m_slave_ready = 1'b1;
    if (cur_bp >= 0 && nb == cur_bp && bp_cnt < 5) begin
      m_slave_ready = 1'b0;
      bp_cnt++;
    end
    m_slave_valid = cur_vmode ? cyc[0] : 1'b1;
    m_rx_data     = (rb < DW) ? cur_rword[rb] : 1'b0;
  endtask

  task automatic start_req(input vec_t v, input bit keep_valid);
    int guard;
    cur_bp = v.bp_at; cur_split = v.split_at; cur_vmode = v.vmode;
    cur_rword = v.rword; cur_lat = v.lat;
    req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1; accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 20) begin tick(); guard++; end
    check("accepted", {31'd0, accepted}, 32'd1);
    req_valid = keep_valid;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin tick(); guard++; end
    check("txn_complete", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc;
    sys_rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    m_grant = 1'b0; m_slave_ready = 1'b0; m_slave_valid = 1'b0; m_rx_data = 1'b0;
    cur_bp = -1; cur_split = -1; cur_vmode = 1'b0; cur_rword = '0; cur_lat = -1;
    model_last = '0; cyc = 0; n_spur = 0; done_cyc = 0; accept_cyc = 0;
    nb = 0; rb = 0; sel_n = 0; bp_cnt = 0; sp_cnt = 0; proto_ok = 1'b1; accepted = 1'b0;
    obs_addr = '0; obs_wd = '0; obs_sel = '0;

    //          wr    addr      wdata  rword  bp  split vm  lat
    vecs[0] = '{1'b1, 14'h2ABC, 8'hA5, 8'h00, -1, -1,   1'b0, 24};
    vecs[1] = '{1'b0, 14'h3001, 8'h00, 8'h3C, -1, -1,   1'b1, -1};
    vecs[2] = '{1'b1, 14'h1555, 8'h5A, 8'h00,  5, -1,   1'b0, 29};
    vecs[3] = '{1'b1, 14'h0F0F, 8'hC3, 8'h00, -1,  6,   1'b0, 34};
    vecs[4] = '{1'b0, 14'h2FFF, 8'h00, 8'h81, -1, 14,   1'b0, 34};
    vecs[5] = '{1'b1, 14'h3000, 8'h00, 8'h00, -1, -1,   1'b0, 24};
    vecs[6] = '{1'b1, 14'h0FFF, 8'hFF, 8'h00, 11, -1,   1'b0, 29};
    vecs[7] = '{1'b0, 14'h0000, 8'h00, 8'hFF, -1, -1,   1'b0, 24};

    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    check("ready_after_reset", {29'd0, req_ready, m_request, rsp_valid}, {29'd0, 3'b100});

    for (int i = 0; i < 8; i++) begin
      start_req(vecs[i], 1'b0);
      drain();
    end

    // Reset mid-address phase: transaction aborted, no completion pulse
    start_req(vecs[0], 1'b0);
    repeat (8) tick();
    sys_rst = 1'b1;
    sb.delete();
    model_last = '0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    check("ready_after_abort", {29'd0, req_ready, m_request, trans_done}, {29'd0, 3'b100});
    repeat (30) tick();
    check("no_spurious_rsp", n_spur, 32'd0);

    // rsp_rdata must read back the cleared value on a following write
    start_req(vecs[5], 1'b0);
    drain();

    // Back-to-back: req_valid held, inputs changed mid-transaction
    start_req(vecs[0], 1'b1);
    first_acc = accept_cyc;
    req_addr = 14'h1234; req_wdata = 8'h77;
    accepted = 1'b0;
    for (int g = 0; g < 60 && !accepted; g++) tick();
    req_valid = 1'b0;
    check("b2b_second_accepted", {31'd0, accepted}, 32'd1);
    check("b2b_accept_cycle", accept_cyc - first_acc, 32'd25);
    check("b2b_after_done", accept_cyc, done_cyc + 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/master_port.md
# master_port

Master-side bus port that converts single-beat parallel read/write requests from a local master into the serial request/grant and valid/ready bit-stream protocol driven into the m1/m2 port of the bus interconnect. It arbitrates for the bus by sending a serial slave select, then transfers address and write data LSB-first, or collects read data, holding its place across grant loss caused by slave split. One instance sits directly upstream of each master port of the interconnect.

## Interface

- ADDR_WIDTH, 14, full request address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] are the 2-bit slave id, bits [ADDR_WIDTH-3:0] are the in-slave address (A = ADDR_WIDTH-2 bits).
- DATA_WIDTH, 8, data word width (D bits).

- sys_clk  in  1  single clock; all state changes on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- req_valid  in  1  local request valid.
- req_ready  out  1  port can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read; sampled on acceptance.
- req_addr  in  ADDR_WIDTH  slave id + address; sampled on acceptance.
- req_wdata  in  DATA_WIDTH  write data; sampled on acceptance.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid for reads, unchanged for writes.
- m_request  out  1  bus request to arbiter.
- m_slave_sel  out  1  serial slave id to arbiter.
- m_grant  in  1  grant from arbiter.
- trans_done  out  1  one-cycle end-of-transaction pulse to arbiter.
- m_master_valid  out  1  address/write-data bit valid.
- m_master_ready  out  1  ready to take a read-data bit.
- m_tx_address  out  1  serial address bit.
- m_tx_data  out  1  serial write-data bit.
- m_rx_data  in  1  serial read-data bit.
- m_write_en  out  1  write transaction in progress.
- m_read_en  out  1  read transaction in progress.
- m_slave_valid  in  1  read-data bit valid.
- m_slave_ready  in  1  slave accepts address/write-data bit.

## Operation

- States: IDLE, SEL, WAIT_GRANT, ADDR, WDATA, RDATA, DONE. One bit counter (width to hold max(A, D)), shift registers for address, wdata, rdata.
- IDLE: req_ready=1. req_valid=1 latches req_write/req_addr/req_wdata, counter=0, -> SEL.
- SEL: 2 cycles, m_request=1, m_slave_sel = slave_id[1] then slave_id[0]; m_grant ignored; -> WAIT_GRANT.
- WAIT_GRANT: m_request=1, m_slave_sel=0. m_grant=1 -> ADDR.
- ADDR: m_master_valid=m_grant, m_tx_address = addr bit[counter] (LSB first). A bit transfers when m_master_valid & m_slave_ready; counter increments. After bit A-1 transfers, counter=0 and -> WDATA (write) or RDATA (read).
- WDATA: as ADDR with m_tx_data = wdata bit[counter], D bits; last transfer -> DONE.
- RDATA: m_master_ready=m_grant; bit captured into rdata[counter] when m_master_ready & m_slave_valid; D bits; last capture -> DONE.
- From WAIT_GRANT to end of data phase: m_request=1, m_write_en=req_write, m_read_en=~req_write.
- Split / grant loss: m_grant=0 in ADDR/WDATA/RDATA freezes state, counter and shift registers; m_master_valid/m_master_ready=0; m_request stays 1; resumes at same bit when m_grant returns.
- DONE: 1 cycle, trans_done=1, rsp_valid=1, m_request=0, all bus outputs 0; rsp_rdata updated for reads; -> IDLE.
- m_tx_address/m_tx_data = 0 whenever m_master_valid=0.

## Timing

- Reset (sys_rst=1 at edge): state IDLE, counter and registers 0, rsp_rdata=0. All outputs 0 while sys_rst high; req_ready=1 from first cycle after release.
- sys_rst mid-transaction aborts immediately: next cycle IDLE, m_request=0, no trans_done/rsp_valid pulse.
- Outputs are decoded from registered state (no input-to-output combinational path except gating by m_grant and bit select).
- Acceptance cycle 0; SEL cycles 1–2; grant sampled from cycle 3. Write, grant at cycle 3, slave always ready: address cycles 4..3+A, data next D cycles, DONE at cycle 4+A+D (24 with defaults). Read: DONE the cycle after the D-th captured bit.
- req_valid while not IDLE is ignored (not latched).

## Test plan

- Reset: hold sys_rst 3 cycles mid-traffic -> all outputs 0, req_ready=1 after release, no rsp_valid.
- Write addr=14'h2ABC, wdata=8'hA5, grant at cycle 3, m_slave_ready=1 -> m_slave_sel 1,0; m_tx_address LSB-first 12'hABC cycles 4–15; m_tx_data 8'hA5 LSB-first cycles 16–23; trans_done and rsp_valid at cycle 24.
- Read addr=14'h3001, m_slave_valid pulsing every other cycle, m_rx_data serial 8'h3C -> rsp_rdata=8'h3C with rsp_valid, m_read_en=1 throughout, m_write_en=0.
- Backpressure: m_slave_ready=0 for 5 cycles mid-address -> address bit held, counter frozen, no bit lost/duplicated.
- Split: drop m_grant after 6 address bits for 10 cycles -> m_master_valid=0, m_request=1 held; resume at bit 6; final bus stream identical to no-split case.
- Back-to-back: req_valid held high for two requests -> second accepted only in IDLE cycle after DONE; req_valid during transaction not latched.
